// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and response-entry layout for the request
// front end, the ALU and the benches that drive them.
package alu_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int TAG_W_DEF = 4;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_SLL  = 4'b0010,
      ALU_SLT  = 4'b0011,
      ALU_SLTU = 4'b0100,
      ALU_XOR  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SRA  = 4'b0111,
      ALU_OR   = 4'b1000,
      ALU_AND  = 4'b1001
   } alu_op_t;

   localparam logic [3:0] ALU_OP_MAX = 4'b1001;

   typedef struct packed {
      logic [XLEN_DEF-1:0]  result;
      logic [TAG_W_DEF-1:0] tag;
      logic                 err;
      logic                 zero;
   } rsp_entry_t;

   function automatic logic op_illegal(input logic [3:0] op);
      return (op > ALU_OP_MAX);
   endfunction

endpackage

// File: rtl/alu_req_ctrl_if.sv
// Request/response handshake bundle between issue logic, the ALU front end
// and the writeback consumer.
interface alu_req_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [XLEN-1:0]  req_a;
   logic [XLEN-1:0]  req_b;
   logic [TAG_W-1:0] req_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [XLEN-1:0]  rsp_result;
   logic [TAG_W-1:0] rsp_tag;
   logic             rsp_err;
   logic             rsp_zero;

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, rsp_zero
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_err, rsp_zero
   );
endinterface

// File: rtl/alu.sv
// Combinational integer ALU; shifts use b[4:0], illegal selects yield zero.
module alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      sel,
   output logic [XLEN-1:0] y
);
   logic [4:0] shamt_s;

   assign shamt_s = b[4:0];

   // Operation select
   always_comb begin
      y = '0;
      case (sel)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << shamt_s;
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> shamt_s;
         ALU_SRA:  y = $unsigned($signed(a) >>> shamt_s);
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = '0;
      endcase
   end
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; the head
// entry is presented from storage and holds while not popped.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [AW:0]      count
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_pop_s  = pop && (count_r != '0);
   assign do_push_s = push && ((count_r < FULL_CNT) || do_pop_s);
   assign pop_data  = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Storage, pointers and count; flush outranks push and pop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: rtl/alu_req_ctrl.sv
// Registered ALU front end: one operand stage feeding the ALU, results queued
// with tag/err/zero in a response FIFO under credit-based flow control.
module alu_req_ctrl
   import alu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int TAG_W     = 4,
   parameter int RSP_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   alu_req_ctrl_if.slave  bus,
   output logic           busy
);
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int EW = XLEN + TAG_W + 2;

   logic             stage_valid_r;
   logic [3:0]       op_r;
   logic [XLEN-1:0]  a_r;
   logic [XLEN-1:0]  b_r;
   logic [TAG_W-1:0] tag_r;

   logic [CW-1:0]    count_s;
   logic [CW:0]      used_s;
   logic             ready_s;
   logic             accept_s;
   logic             push_s;
   logic             err_s;
   logic             zero_s;
   logic [XLEN-1:0]  alu_y_s;
   logic [XLEN-1:0]  result_s;
   logic [EW-1:0]    push_data_s;
   logic [EW-1:0]    head_s;

   // Stage plus queued entries may never exceed the FIFO, so no overflow check is needed on push
   assign used_s   = {1'b0, count_s} + {{CW{1'b0}}, stage_valid_r};
   assign ready_s  = (used_s < (CW+1)'(RSP_DEPTH));
   assign accept_s = bus.req_valid && ready_s && !flush;
   assign push_s   = stage_valid_r && !flush;

   assign err_s       = op_illegal(op_r);
   assign result_s    = err_s ? '0 : alu_y_s;
   assign zero_s      = (result_s == '0);
   assign push_data_s = {result_s, tag_r, err_s, zero_s};

   // Operand stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_valid_r <= 1'b0;
         op_r          <= 4'b0000;
         a_r           <= '0;
         b_r           <= '0;
         tag_r         <= '0;
      end else if (flush) begin
         stage_valid_r <= 1'b0;
      end else begin
         stage_valid_r <= accept_s;
         if (accept_s) begin
            op_r  <= bus.req_op;
            a_r   <= bus.req_a;
            b_r   <= bus.req_b;
            tag_r <= bus.req_tag;
         end
      end
   end

   alu #(.XLEN(XLEN)) u_alu (
      .a   (a_r),
      .b   (b_r),
      .sel (op_r),
      .y   (alu_y_s)
   );

   sync_fifo #(.WIDTH(EW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (bus.rsp_ready),
      .pop_data  (head_s),
      .count     (count_s)
   );

   assign bus.req_ready = ready_s;
   assign bus.rsp_valid = (count_s != '0);
   assign {bus.rsp_result, bus.rsp_tag, bus.rsp_err, bus.rsp_zero} = head_s;
   assign busy = stage_valid_r || (count_s != '0);
endmodule

// File: tb/tb_alu_req_ctrl.sv
// Randomised scoreboard bench for alu_req_ctrl: accepted requests are modelled
// arithmetically and queued; a monitor compares every response handshake.
module tb_alu_req_ctrl;
   import alu_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 4;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic busy;

   int n_cmp = 0;
   int n_err = 0;
   int stalls = 0;
   int n_pop = 0;
   logic rand_ready = 1'b0;
   logic stall_seen = 1'b0;
   rsp_entry_t stall_val;
   rsp_entry_t exp_q[$];

   alu_req_ctrl_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   alu_req_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour written from the opcode definitions with wide integer arithmetic
   function automatic rsp_entry_t model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [3:0] tag);
      rsp_entry_t e;
      longint unsigned ua, ub;
      longint sa, sb;
      int sh;
      logic [31:0] r;
      ua = 64'(a);
      ub = 64'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sh = int'(b[4:0]);
      case (op)
         4'd0:    r = 32'(ua + ub);
         4'd1:    r = 32'(ua - ub);
         4'd2:    r = 32'(ua << sh);
         4'd3:    r = (sa < sb) ? 32'd1 : 32'd0;
         4'd4:    r = (ua < ub) ? 32'd1 : 32'd0;
         4'd5:    r = a ^ b;
         4'd6:    r = 32'(ua >> sh);
         4'd7:    r = 32'(sa >>> sh);
         4'd8:    r = a | b;
         4'd9:    r = a & b;
         default: r = 32'd0;
      endcase
      e.result = r;
      e.tag    = tag;
      e.err    = (op > 4'd9);
      e.zero   = (r == 32'd0);
      return e;
   endfunction

   // Scoreboard: push on observed accept, pop/compare on observed response, check stall stability
   always @(negedge clk) begin
      rsp_entry_t head;
      rsp_entry_t want;
      if (rst_n) begin
         head = rsp_entry_t'({bus.rsp_result, bus.rsp_tag, bus.rsp_err, bus.rsp_zero});
         if (stall_seen)
            check("stall_hold", 64'({bus.rsp_valid, head}), 64'({1'b1, stall_val}));
         if (flush) begin
            exp_q.delete();
            stall_seen = 1'b0;
         end else begin
            if (bus.rsp_valid && bus.rsp_ready) begin
               n_pop++;
               check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
               if (exp_q.size() != 0) begin
                  want = exp_q.pop_front();
                  check("rsp", 64'(head), 64'(want));
               end
            end
            stall_seen = bus.rsp_valid && !bus.rsp_ready;
            stall_val  = head;
            if (bus.req_valid && bus.req_ready)
               exp_q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_tag));
         end
      end
   end

   always @(negedge rst_n) begin
      exp_q.delete();
      stall_seen = 1'b0;
   end

   // Random consumer back-pressure
   always @(posedge clk) begin
      #2;
      if (rand_ready) bus.rsp_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag);
      int waited = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_tag   = tag;
      while (!bus.req_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!bus.req_ready) begin
         check("req_ready_timeout", 64'(bus.req_ready), 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      stalls += waited;
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int waited = 0;
      while ((bus.rsp_valid || busy) && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      check("drain_busy", 64'(busy), 64'd0);
   endtask

   logic [3:0]  d_op  [12] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd3, 4'd4, 4'd7, 4'd6, 4'd5, 4'hC, 4'd0};
   logic [31:0] d_a   [12] = '{32'd5, 32'd7, 32'd1, 32'd8, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'h8000_0000, 32'h8000_0000, 32'hF0, 32'd5, 32'd2};
   logic [31:0] d_b   [12] = '{32'd1, 32'd4, 32'd0, 32'd3, 32'd2, 32'd1, 32'd1,
                               32'd4, 32'd4, 32'hFF, 32'd1, 32'd3};
   logic [31:0] d_res [12] = '{32'd6, 32'd3, 32'd1, 32'd11, 32'd0, 32'd1, 32'd0,
                               32'hF800_0000, 32'h0800_0000, 32'h0F, 32'd0, 32'd5};
   logic        d_bad [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   initial begin
      int accepted;
      int pops0;
      logic [3:0] tag;
      logic [32:0] wide_a;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = 32'd0;
      bus.req_b     = 32'd0;
      bus.req_tag   = 4'd0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("reset_ctrl", 64'({bus.rsp_valid, busy, bus.req_ready}), 64'({1'b0, 1'b0, 1'b1}));
      check("reset_data", 64'({bus.rsp_result, bus.rsp_tag, bus.rsp_err, bus.rsp_zero}), 64'd0);

      // Directed single ops, one in flight, checking one-cycle latency
      bus.rsp_ready = 1'b1;
      wide_a = 33'h1_0000_0004;
      d_a[4] = wide_a[31:0];
      for (int i = 0; i < 12; i++) begin
         send(d_op[i], d_a[i], d_b[i], 4'(i + 1));
         check("dir_not_early", 64'(bus.rsp_valid), 64'd0);
         @(posedge clk); #1;
         check("dir_rsp", 64'({bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.rsp_err, bus.rsp_zero}),
               64'({1'b1, d_res[i], 4'(i + 1), d_bad[i], (d_res[i] == 32'd0)}));
      end
      drain();

      // Back-pressure: exactly DEPTH accepts while the consumer stalls
      bus.rsp_ready = 1'b0;
      accepted = 0;
      tag = 4'd0;
      bus.req_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         bus.req_tag = tag;
         bus.req_op  = 4'($urandom_range(0, 9));
         bus.req_a   = $urandom;
         bus.req_b   = $urandom;
         if (bus.req_ready) begin
            accepted++;
            tag = tag + 4'd1;
         end
         @(posedge clk); #1;
      end
      bus.req_valid = 1'b0;
      check("bp_accepted", 64'(accepted), 64'(DEPTH));
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      drain();

      // Flush with three entries queued
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(4'($urandom_range(0, 9)), $urandom, $urandom, 4'(i));
      @(posedge clk); #1;
      check("pre_flush_busy", 64'(busy), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_state", 64'({bus.rsp_valid, busy, bus.req_ready}), 64'({1'b0, 1'b0, 1'b1}));
      bus.rsp_ready = 1'b1;
      send(4'd0, 32'd40, 32'd2, 4'd9);
      drain();

      // Asynchronous reset between edges with entries queued
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(4'($urandom_range(0, 9)), $urandom, $urandom, 4'(i));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("async_reset", 64'({bus.rsp_valid, busy, bus.req_ready}), 64'({1'b0, 1'b0, 1'b1}));
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      send(4'd1, 32'd10, 32'd3, 4'd5);
      drain();
      check("post_reset_queue", 64'(exp_q.size()), 64'd0);

      // Streaming legal ops at full rate
      stalls = 0;
      pops0 = n_pop;
      for (int i = 0; i < 100; i++)
         send(4'($urandom_range(0, 9)), $urandom, (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom, 4'(i));
      drain();
      check("stream_stalls", 64'(stalls), 64'd0);
      check("stream_count", 64'(n_pop - pops0), 64'd100);

      // Streaming with random consumer readiness, illegal ops included
      pops0 = n_pop;
      rand_ready = 1'b1;
      for (int i = 0; i < 100; i++)
         send(4'($urandom_range(0, 15)), $urandom, $urandom, 4'(i));
      rand_ready = 1'b0;
      bus.rsp_ready = 1'b1;
      drain();
      check("rand_count", 64'(n_pop - pops0), 64'd100);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
